// File: rtl/io_input_cond.sv
// io_input_cond: 2-flop sync, counter debounce and press pulses for board switches/buttons.
// Define IO_INPUT_COND_STICKY_EN to add sticky press flags with per-button clear.
module io_input_cond #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_sw_raw,
  input  logic [3:0]  i_btn_raw,
  output logic [31:0] o_io_sw,
  output logic [3:0]  o_io_btn,
  output logic [3:0]  o_btn_press
`ifdef IO_INPUT_COND_STICKY_EN
  ,
  input  logic [3:0]  i_btn_clr,
  output logic [3:0]  o_btn_sticky
`endif
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [35:0] w_raw, w_upd, r_s1, r_s2, r_out;
  logic [3:0]  r_press;
  assign w_raw = {(BTN_ACTIVE_LOW != 0) ? ~i_btn_raw : i_btn_raw, i_sw_raw};
  for (genvar c = 0; c < 36; c++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    // Commit only after DEBOUNCE_CYCLES consecutive samples disagreeing with the output.
    assign w_upd[c] = (r_s2[c] != r_out[c]) && (r_cnt == CNT_MAX);
    always_ff @(posedge i_clk)
      r_cnt <= (!i_rst_n || r_s2[c] == r_out[c] || w_upd[c]) ? '0 : r_cnt + 1'b1;
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_out   <= '0;
      r_press <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_out   <= r_out ^ w_upd;
      r_press <= w_upd[35:32] & ~r_out[35:32];
    end
  assign o_io_sw     = r_out[31:0];
  assign o_io_btn    = r_out[35:32];
  assign o_btn_press = r_press;
`ifdef IO_INPUT_COND_STICKY_EN
  logic [3:0] r_sticky;
  always_ff @(posedge i_clk)
    r_sticky <= !i_rst_n ? '0 : r_press | (r_sticky & ~i_btn_clr);
  assign o_btn_sticky = r_sticky;
`endif
endmodule

// File: tb/tb_io_input_cond.sv
// tb_io_input_cond: directed plus random stimulus against a sliding-window debounce model.
module tb_io_input_cond;
  localparam int D = 4;
  logic        clk = 0, rst_n = 0;
  logic [31:0] sw_raw = 0, io_sw;
  logic [3:0]  btn_raw = 4'hF, io_btn, press;
  int          n_vec = 0, n_err = 0;
`ifdef IO_INPUT_COND_STICKY_EN
  logic [3:0]  clr = 0, sticky;
`endif

  always #5 clk = ~clk;

  io_input_cond #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_raw(sw_raw), .i_btn_raw(btn_raw),
    .o_io_sw(io_sw), .o_io_btn(io_btn), .o_btn_press(press)
`ifdef IO_INPUT_COND_STICKY_EN
    , .i_btn_clr(clr), .o_btn_sticky(sticky)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: an output flips when the last D synchronised samples all disagree with it.
  bit [35:0]  m_s1, m_s2, m_out;
  bit [D-1:0] m_win [36];
  bit [3:0]   m_press, m_sticky;
  always @(posedge clk) begin
    bit [35:0] raw, nout;
    raw = {~btn_raw, sw_raw};
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_out = 0; m_press = 0; m_sticky = 0;
      for (int c = 0; c < 36; c++) m_win[c] = 0;
    end else begin
      for (int c = 0; c < 36; c++) begin
        m_win[c] = {m_win[c][D-2:0], m_s2[c]};
        nout[c] = (m_win[c] == {D{~m_out[c]}}) ? ~m_out[c] : m_out[c];
      end
`ifdef IO_INPUT_COND_STICKY_EN
      m_sticky = m_press | (m_sticky & ~clr);
`endif
      m_press = nout[35:32] & ~m_out[35:32];
      m_out = nout;
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  always @(negedge clk) begin
    chk("sw", io_sw, m_out[31:0]);
    chk("btn", {28'd0, io_btn}, {28'd0, m_out[35:32]});
    chk("press", {28'd0, press}, {28'd0, m_press});
`ifdef IO_INPUT_COND_STICKY_EN
    chk("sticky", {28'd0, sticky}, {28'd0, m_sticky});
`endif
  end

  initial begin
    // reset with buttons released
    repeat (3) @(posedge clk);
    #1 chk("rst_sw", io_sw, 0); chk("rst_btn", {28'd0, io_btn}, 0); chk("rst_press", {28'd0, press}, 0);
    @(negedge clk) rst_n = 1;
    repeat (10) @(posedge clk);
    #1 chk("idle_sw", io_sw, 0); chk("idle_btn", {28'd0, io_btn}, 0);
    // clean switch edge: visible at edge 6, not 5
    @(negedge clk) sw_raw[5] = 1;
    repeat (5) @(posedge clk);
    #1 chk("sw5_e5", io_sw, 0);
    @(posedge clk);
    #1 chk("sw5_e6", io_sw, 32'h20);
    // bouncing button 2
    for (int i = 0; i < 20; i++) begin
      @(negedge clk) btn_raw[2] = (i % 3 == 2);
      @(posedge clk);
      #1 chk("glitch_btn", {28'd0, io_btn}, 0);
    end
    repeat (3) begin
      @(posedge clk);
      #1 chk("settle_btn", {28'd0, io_btn}, 0);
    end
    @(posedge clk);
    #1 chk("b2_rise", {28'd0, io_btn}, 4); chk("b2_press", {28'd0, press}, 4);
    @(posedge clk);
    #1 chk("b2_hold", {28'd0, io_btn}, 4); chk("b2_press_end", {28'd0, press}, 0);
    // all buttons together
    @(negedge clk) btn_raw = 4'hF;
    repeat (10) @(posedge clk);
    #1 chk("rel_btn", {28'd0, io_btn}, 0);
    @(negedge clk) btn_raw = 4'h0;
    repeat (5) @(posedge clk);
    #1 chk("all_e5", {28'd0, io_btn}, 0);
    @(posedge clk);
    #1 chk("all_e6", {28'd0, io_btn}, 4'hF); chk("all_press", {28'd0, press}, 4'hF);
    repeat (44) begin
      @(posedge clk);
      #1 chk("all_held", {28'd0, press}, 0);
    end
    @(negedge clk) btn_raw = 4'hF;
    repeat (5) begin
      @(posedge clk);
      #1 chk("rel_wait", {28'd0, io_btn}, 4'hF); chk("rel_nopulse", {28'd0, press}, 0);
    end
    @(posedge clk);
    #1 chk("rel_e6", {28'd0, io_btn}, 0); chk("rel_nopulse6", {28'd0, press}, 0);
    // reset mid-debounce on button 0
    @(negedge clk) btn_raw = 4'hE;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 0;
    repeat (2) @(posedge clk);
    #1 chk("mid_rst_btn", {28'd0, io_btn}, 0); chk("mid_rst_press", {28'd0, press}, 0);
    @(negedge clk) rst_n = 1;
    repeat (5) begin
      @(posedge clk);
      #1 chk("post_rst_wait", {28'd0, io_btn}, 0);
    end
    @(posedge clk);
    #1 chk("post_rst_rise", {28'd0, io_btn}, 1); chk("post_rst_press", {28'd0, press}, 1);
    @(posedge clk);
    #1 chk("post_rst_once", {28'd0, press}, 0);
`ifdef IO_INPUT_COND_STICKY_EN
    // clear collides with set: set wins; a later clear drops the flag
    @(negedge clk) btn_raw = 4'hF;
    repeat (10) @(posedge clk);
    @(negedge clk) btn_raw = 4'hD;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk);
        #1 seen = press[1];
      end
      chk("stk_press_seen", {31'd0, seen}, 1);
    end
    clr = 4'h2;
    @(posedge clk);
    #1 chk("stk_set_wins", {31'd0, sticky[1]}, 1);
    clr = 0;
    repeat (3) @(posedge clk);
    #1 clr = 4'h2;
    @(posedge clk);
    #1 clr = 0; chk("stk_cleared", {31'd0, sticky[1]}, 0);
`endif
    // random traffic
    repeat (800) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, 35);
        if (k < 32) sw_raw[k] = ~sw_raw[k];
        else btn_raw[k-32] = ~btn_raw[k-32];
      end
      rst_n = ($urandom_range(0, 299) != 0);
`ifdef IO_INPUT_COND_STICKY_EN
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
`endif
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
